// File: rtl/wb_arbiter.sv
// Two-requester Wishbone arbiter with alternating priority on contention.
// Optional stall timeout is enabled with the WB_ARBITER_TIMEOUT_EN macro.
module wb_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_cyc,
  input  logic                  s0_stb,
  input  logic                  s0_we,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_data_write,
  output logic                  s0_ack,
  output logic                  s0_err,
  output logic [DATA_WIDTH-1:0] s0_data_read,
  input  logic                  s1_cyc,
  input  logic                  s1_stb,
  input  logic                  s1_we,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_data_write,
  output logic                  s1_ack,
  output logic                  s1_err,
  output logic [DATA_WIDTH-1:0] s1_data_read,
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data_write,
  input  logic                  m_ack,
  input  logic                  m_err,
  input  logic [DATA_WIDTH-1:0] m_data_read
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t state_q;
  logic   lg_q;
  logic   gnt0, gnt1;
  logic   stb_raw;
  logic   stb_block;
  logic   tmo_hit;

  // lg_q starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lg_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (s0_cyc && (!s1_cyc || lg_q)) begin
            state_q <= GNT0;
            lg_q    <= 1'b0;
          end else if (s1_cyc) begin
            state_q <= GNT1;
            lg_q    <= 1'b1;
          end
        end
        GNT0:    if (!s0_cyc) state_q <= IDLE;
        GNT1:    if (!s1_cyc) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  always_comb begin
    m_cyc        = 1'b0;
    stb_raw      = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_data_write = '0;
    if (gnt0) begin
      m_cyc        = s0_cyc;
      stb_raw      = s0_stb;
      m_we         = s0_we;
      m_addr       = s0_addr;
      m_data_write = s0_data_write;
    end else if (gnt1) begin
      m_cyc        = s1_cyc;
      stb_raw      = s1_stb;
      m_we         = s1_we;
      m_addr       = s1_addr;
      m_data_write = s1_data_write;
    end
  end

  assign m_stb = stb_raw & ~stb_block;

  // Terminations only reach the owner; in IDLE both gates are closed.
  assign s0_ack       = gnt0 & m_ack;
  assign s0_err       = gnt0 & (m_err | tmo_hit);
  assign s1_ack       = gnt1 & m_ack;
  assign s1_err       = gnt1 & (m_err | tmo_hit);
  assign s0_data_read = m_data_read;
  assign s1_data_read = m_data_read;

`ifdef WB_ARBITER_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       block_q;
  logic       stall;

  // The current stalled cycle is the (cnt_q+1)-th, so the limit fires at TIMEOUT-1.
  assign stall   = m_cyc & m_stb & ~m_ack & ~m_err;
  assign tmo_hit = stall && (cnt_q == TMO_LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!stall || tmo_hit) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      block_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= tmo_hit;
    end
  end

  assign stb_block = block_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LAST;
  assign tmo_hit    = 1'b0;
  assign stb_block  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; terminations are matched against a scoreboard queue.
module tb_wb_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  localparam logic [3:0] S0ERR = 4'b0001;
  localparam logic [3:0] S0ACK = 4'b0010;
  localparam logic [3:0] S1ACK = 4'b1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_cyc = 1'b0, s0_stb = 1'b0, s0_we = 1'b0;
  logic [AW-1:0] s0_addr = '0;
  logic [DW-1:0] s0_data_write = '0;
  logic          s0_ack, s0_err;
  logic [DW-1:0] s0_data_read;
  logic          s1_cyc = 1'b0, s1_stb = 1'b0, s1_we = 1'b0;
  logic [AW-1:0] s1_addr = '0;
  logic [DW-1:0] s1_data_write = '0;
  logic          s1_ack, s1_err;
  logic [DW-1:0] s1_data_read;
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_write;
  logic          m_ack = 1'b0, m_err = 1'b0;
  logic [DW-1:0] m_data_read = '0;

  typedef struct {
    logic [3:0]    flags;
    logic [DW-1:0] data;
    logic          chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .s0_cyc(s0_cyc), .s0_stb(s0_stb), .s0_we(s0_we), .s0_addr(s0_addr),
    .s0_data_write(s0_data_write), .s0_ack(s0_ack), .s0_err(s0_err),
    .s0_data_read(s0_data_read),
    .s1_cyc(s1_cyc), .s1_stb(s1_stb), .s1_we(s1_we), .s1_addr(s1_addr),
    .s1_data_write(s1_data_write), .s1_ack(s1_ack), .s1_err(s1_err),
    .s1_data_read(s1_data_read),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_data_write(m_data_write), .m_ack(m_ack), .m_err(m_err),
    .m_data_read(m_data_read)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic expect_term(input logic [3:0] fl, input logic [DW-1:0] d, input logic cd);
    exp_t e;
    e.flags = fl; e.data = d; e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Monitor: every termination seen on a requester must match the queue head.
  always @(negedge clk) begin
    logic [3:0] fl;
    exp_t       e;
    fl = {s1_ack, s1_err, s0_ack, s0_err};
    if (fl != 4'b0000) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_term: got flags 0x%0h, expected none", fl);
      end else begin
        e = sb.pop_front();
        check("term_flags", 32'(fl), 32'(e.flags));
        if (e.chk_data)
          check("term_data", 32'(fl[3] ? s1_data_read : s0_data_read), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a stray slave ack present
    m_ack = 1'b1;
    neg();
    check("rst_m_cyc", 32'(m_cyc), 0);
    check("rst_m_stb", 32'(m_stb), 0);
    check("rst_term", 32'({s1_ack, s1_err, s0_ack, s0_err}), 0);
    nxt();
    m_ack = 1'b0;
    rst   = 1'b0;
    nxt();

    // Single read by s0, acked on the 3rd granted cycle
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_addr = 16'h1234;
    neg(); check("lat_idle_m_cyc", 32'(m_cyc), 0);
    nxt();
    neg(); check("lat_gnt_m_cyc", 32'(m_cyc), 1);
    check("rd_m_addr", 32'(m_addr), 32'h1234);
    check("rd_m_we", 32'(m_we), 0);
    nxt();
    nxt();
    m_ack = 1'b1; m_data_read = 16'hBEEF;
    expect_term(S0ACK, 16'hBEEF, 1'b1);
    neg();
    nxt();
    m_ack = 1'b0; s0_cyc = 1'b0; s0_stb = 1'b0;
    neg(); check("rel_m_cyc", 32'(m_cyc), 0);
    nxt();

    // Tie after reset: s0, dead cycle, s1, then s0 again
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b1; s0_addr = 16'hA000;
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_we = 1'b1; s1_addr = 16'hB000;
    nxt();
    m_ack = 1'b1; m_data_read = 16'h1111;
    expect_term(S0ACK, 16'h1111, 1'b1);
    neg(); check("tie1_m_addr", 32'(m_addr), 32'hA000);
    check("tie1_m_we", 32'(m_we), 1);
    nxt();
    m_ack = 1'b0; s0_cyc = 1'b0; s0_stb = 1'b0;
    neg(); check("tie1_rel_m_cyc", 32'(m_cyc), 0);
    nxt();
    m_ack = 1'b1; m_data_read = 16'hDEAD;
    neg(); check("dead_m_cyc", 32'(m_cyc), 0);
    nxt();
    m_ack = 1'b1; m_data_read = 16'h2222;
    expect_term(S1ACK, 16'h2222, 1'b1);
    neg(); check("tie2_m_addr", 32'(m_addr), 32'hB000);
    check("tie2_m_cyc", 32'(m_cyc), 1);
    nxt();
    m_ack = 1'b0; s1_cyc = 1'b0; s1_stb = 1'b0;
    nxt();
    s0_cyc = 1'b1; s0_stb = 1'b1; s1_cyc = 1'b1; s1_stb = 1'b1;
    nxt();
    neg(); check("tie3_m_addr", 32'(m_addr), 32'hA000);
    nxt();
    s0_cyc = 1'b0; s0_stb = 1'b0; s1_cyc = 1'b0; s1_stb = 1'b0;
    nxt();

    // s1 burst of 4 writes while s0 waits
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_addr = 16'hC000;
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_we = 1'b1; s1_addr = 16'h0010;
    nxt();
    for (int i = 0; i < 4; i++) begin
      s1_addr = 16'h0010 + 16'(i);
      m_ack = 1'b1; m_data_read = 16'h5000 + 16'(i);
      expect_term(S1ACK, 16'h5000 + 16'(i), 1'b1);
      neg();
      check("burst_m_addr", 32'(m_addr), 32'h0010 + 32'(i));
      check("burst_m_cyc", 32'(m_cyc), 1);
      nxt();
    end
    m_ack = 1'b0; s1_cyc = 1'b0; s1_stb = 1'b0;
    neg(); check("burst_rel_m_cyc", 32'(m_cyc), 0);
    nxt();
    neg(); check("burst_dead_m_cyc", 32'(m_cyc), 0);
    nxt();
    m_ack = 1'b1; m_data_read = 16'h6000;
    expect_term(S0ACK, 16'h6000, 1'b1);
    neg(); check("wait_s0_m_addr", 32'(m_addr), 32'hC000);
    nxt();
    m_ack = 1'b0; s0_cyc = 1'b0; s0_stb = 1'b0;
    nxt();

    // Reset mid GNT1 write with a late slave ack
    s1_cyc = 1'b1; s1_stb = 1'b1; s1_we = 1'b1; s1_addr = 16'h0020;
    nxt();
    neg(); check("g1_m_cyc", 32'(m_cyc), 1);
    nxt();
    rst = 1'b1; m_ack = 1'b1;
    #1 check("rst_mid_m_cyc", 32'(m_cyc), 0);
    neg(); check("rst_mid_s1_ack", 32'(s1_ack), 0);
    nxt();
    rst = 1'b0; m_ack = 1'b0;
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_addr = 16'hC000;
    nxt();
    neg(); check("post_rst_tie_m_addr", 32'(m_addr), 32'hC000);
    nxt();
    s0_cyc = 1'b0; s0_stb = 1'b0; s1_cyc = 1'b0; s1_stb = 1'b0;
    nxt();

`ifdef WB_ARBITER_TIMEOUT_EN
    // Stalled slave: err on the 4th stalled cycle, strobe masked next
    s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_addr = 16'h7000;
    nxt();
    nxt();
    nxt();
    nxt();
    expect_term(S0ERR, '0, 1'b0);
    neg(); check("tmo_stb_hit", 32'(m_stb), 1);
    nxt();
    neg(); check("tmo_stb_mask", 32'(m_stb), 0);
    check("tmo_cyc_hold", 32'(m_cyc), 1);
    nxt();
    s0_cyc = 1'b0; s0_stb = 1'b0;
    nxt();
    s0_cyc = 1'b1; s0_stb = 1'b1;
    nxt();
    nxt();
    nxt();
    nxt();
    m_ack = 1'b1; m_data_read = 16'h8000;
    expect_term(S0ACK, 16'h8000, 1'b1);
    neg();
    nxt();
    m_ack = 1'b0;
    neg(); check("tmo_ack_stb", 32'(m_stb), 1);
    nxt();
    s0_cyc = 1'b0; s0_stb = 1'b0;
    nxt();
`endif

    nxt();
    neg(); check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
